// File: rtl/uart_cmd_responder_if.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | uart_cmd_responder_if : UART byte handshake + register-bus signal bundle   |
// | Rev 1.0                                                                     |
// +----------------------------------------------------------------------------+
interface uart_cmd_responder_if #(
  parameter int ADDR_W = 4
);
  logic              RX_done;
  logic [7:0]        RX_data;
  logic              tx_ready;
  logic [7:0]        TX_data;
  logic              start_tx;
  logic [ADDR_W-1:0] reg_addr;
  logic [7:0]        reg_wdata;
  logic              reg_wr_en;
  logic [7:0]        reg_rdata;
  logic              busy;
  logic              overrun;

  // The responder drives the register bus, hence it is the master side.
  modport master (
    input  RX_done, RX_data, tx_ready, reg_rdata,
    output TX_data, start_tx, reg_addr, reg_wdata, reg_wr_en, busy, overrun
  );

  modport slave (
    output RX_done, RX_data, tx_ready, reg_rdata,
    input  TX_data, start_tx, reg_addr, reg_wdata, reg_wr_en, busy, overrun
  );
endinterface
`default_nettype wire

// File: rtl/uart_cmd_responder.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | uart_cmd_responder : 'W' A D / 'R' A command decoder, one reply byte each   |
// | Rev 1.0                                                                     |
// +----------------------------------------------------------------------------+
module uart_cmd_responder #(
  parameter int ADDR_W         = 4,
  parameter int TIMEOUT_CYCLES = 100000000
) (
  input  wire logic               clk,
  input  wire logic               reset,
  uart_cmd_responder_if.master    bus
);

  localparam int              CNT_W      = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [CNT_W-1:0] c_TMO_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  localparam logic [7:0] c_OP_WR   = 8'h57;
  localparam logic [7:0] c_OP_RD   = 8'h52;
  localparam logic [7:0] c_RSP_OK  = 8'h4B;
  localparam logic [7:0] c_RSP_ERR = 8'h3F;

  localparam logic [2:0] c_IDLE          = 3'd0;
  localparam logic [2:0] c_GET_ADDR      = 3'd1;
  localparam logic [2:0] c_GET_DATA      = 3'd2;
  localparam logic [2:0] c_RD_SAMPLE     = 3'd3;
  localparam logic [2:0] c_WR_STROBE     = 3'd4;
  localparam logic [2:0] c_TX_WAIT_READY = 3'd5;
  localparam logic [2:0] c_TX_WAIT_ACK   = 3'd6;

  logic [2:0]        state_q, state_d;
  logic              rx_done_q;
  logic              is_wr_q, is_wr_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [7:0]        wdata_q, wdata_d;
  logic [7:0]        reply_q, reply_d;
  logic [7:0]        tx_data_q, tx_data_d;
  logic              start_tx_q, start_tx_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;

  logic w_rx_stb;
  logic w_in_cmd;
  logic w_tmo_hit;
  logic w_reg_wr_en;
  logic w_busy;
  logic w_overrun;

  assign w_rx_stb  = bus.RX_done & ~rx_done_q;
  assign w_in_cmd  = (state_q == c_GET_ADDR) || (state_q == c_GET_DATA);
  // An arriving byte wins over an expiring timeout in the same cycle.
  assign w_tmo_hit = w_in_cmd && !w_rx_stb && (cnt_q == c_TMO_LAST);

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= c_IDLE;
      rx_done_q  <= 1'b0;
      is_wr_q    <= 1'b0;
      addr_q     <= '0;
      wdata_q    <= 8'h00;
      reply_q    <= 8'h00;
      tx_data_q  <= 8'h00;
      start_tx_q <= 1'b0;
      cnt_q      <= '0;
    end else begin
      state_q    <= state_d;
      rx_done_q  <= bus.RX_done;
      is_wr_q    <= is_wr_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      reply_q    <= reply_d;
      tx_data_q  <= tx_data_d;
      start_tx_q <= start_tx_d;
      cnt_q      <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      c_IDLE:
        if (w_rx_stb) begin
          if (bus.RX_data == c_OP_WR || bus.RX_data == c_OP_RD) state_d = c_GET_ADDR;
          else                                                  state_d = c_TX_WAIT_READY;
        end
      c_GET_ADDR:
        if (w_rx_stb)       state_d = is_wr_q ? c_GET_DATA : c_RD_SAMPLE;
        else if (w_tmo_hit) state_d = c_IDLE;
      c_GET_DATA:
        if (w_rx_stb)       state_d = c_WR_STROBE;
        else if (w_tmo_hit) state_d = c_IDLE;
      c_RD_SAMPLE,
      c_WR_STROBE:          state_d = c_TX_WAIT_READY;
      c_TX_WAIT_READY:
        if (bus.tx_ready)   state_d = c_TX_WAIT_ACK;
      // Wait for the transmitter to drop ready so a lagging ready cannot retrigger.
      c_TX_WAIT_ACK:
        if (!bus.tx_ready)  state_d = c_IDLE;
      default:              state_d = c_IDLE;
    endcase
  end

  always_comb begin
    is_wr_d     = is_wr_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    reply_d     = reply_q;
    tx_data_d   = tx_data_q;
    start_tx_d  = 1'b0;
    cnt_d       = (w_in_cmd && !w_rx_stb && !w_tmo_hit) ? cnt_q + CNT_W'(1) : '0;
    w_reg_wr_en = (state_q == c_WR_STROBE);
    w_busy      = (state_q != c_IDLE);
    w_overrun   = w_rx_stb && (state_q inside {c_RD_SAMPLE, c_WR_STROBE,
                                               c_TX_WAIT_READY, c_TX_WAIT_ACK});
    case (state_q)
      c_IDLE:
        if (w_rx_stb) begin
          is_wr_d = (bus.RX_data == c_OP_WR);
          if (bus.RX_data != c_OP_WR && bus.RX_data != c_OP_RD) reply_d = c_RSP_ERR;
        end
      c_GET_ADDR:
        if (w_rx_stb) addr_d = bus.RX_data[ADDR_W-1:0];
      c_GET_DATA:
        if (w_rx_stb) wdata_d = bus.RX_data;
      c_RD_SAMPLE:     reply_d = bus.reg_rdata;
      c_WR_STROBE:     reply_d = c_RSP_OK;
      c_TX_WAIT_READY:
        if (bus.tx_ready) begin
          start_tx_d = 1'b1;
          tx_data_d  = reply_q;
        end
      default: ;
    endcase
  end

  assign bus.TX_data   = tx_data_q;
  assign bus.start_tx  = start_tx_q;
  assign bus.reg_addr  = addr_q;
  assign bus.reg_wdata = wdata_q;
  assign bus.reg_wr_en = w_reg_wr_en;
  assign bus.busy      = w_busy;
  assign bus.overrun   = w_overrun;

endmodule
`default_nettype wire
